hbuf_rdout_drain: RTL

- Consumes the 64-bit read port of the readout DPRAM that wvb_reader fills.
- Answers wvb_reader's dpram_run/dpram_busy handshake: latches dpram_len, reads the DPRAM sequentially, serialises each 64-bit word into four 16-bit words on a valid/ready stream, then raises dpram_done and drops dpram_busy.
- The stream feeds the host-interface FIFO.

---
 rtl/hbuf_rdout_drain_if.sv | 27 ++
 rtl/hbuf_rdout_drain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hbuf_rdout_drain_if.sv
// Bundle between the readout drain, wvb_reader's DPRAM handshake and read port,
// and the 16-bit stream toward the host-interface FIFO.
interface hbuf_rdout_drain_if #(
    parameter int P_RD_ADR_WIDTH = 9,
    parameter int P_LEN_WIDTH    = 16
);
    logic                      dpram_run;
    logic [P_LEN_WIDTH-1:0]    dpram_len;
    logic                      dpram_busy;
    logic                      dpram_done;
    logic [P_RD_ADR_WIDTH-1:0] rd_addr;
    logic [63:0]               rd_data;
    logic [15:0]               out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (
        input  dpram_run, dpram_len, rd_data, out_ready,
        output dpram_busy, dpram_done, rd_addr, out_data, out_valid, out_last
    );

    modport slave (
        output dpram_run, dpram_len, rd_data, out_ready,
        input  dpram_busy, dpram_done, rd_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/hbuf_rdout_drain.sv
// Drains the readout DPRAM filled by wvb_reader: reads 64-bit words sequentially
// and serialises each into four 16-bit stream words, lowest half-word first.
module hbuf_rdout_drain #(
    parameter int P_RD_ADR_WIDTH = 9,
    parameter int P_LEN_WIDTH    = 16,
    parameter int P_RD_LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    hbuf_rdout_drain_if.master  bus,
    output logic                err_len,
    output logic [31:0]         n_rdouts
);

    localparam int C_MAX_LEN = 4 * (2 ** P_RD_ADR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [P_LEN_WIDTH-1:0]    len_r;
    logic [P_RD_ADR_WIDTH-1:0] addr_r;
    logic [1:0]                wait_r;
    logic [63:0]               hold_r;
    logic [1:0]                k_r;
    logic [15:0]               out_data_r;
    logic                      out_valid_r;
    logic                      out_last_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      err_r;
    logic [31:0]               n_r;

    logic [P_LEN_WIDTH-1:0]    last_idx_s;
    logic                      is_last_word_s;
    logic                      hs_s;
    logic                      start_s;
    logic                      reject_s;
    logic                      capture_s;
    logic                      word_end_s;
    logic                      final_s;

    function automatic logic f_len_legal(input logic [P_LEN_WIDTH-1:0] len);
        f_len_legal = (len != '0) && (len[1:0] == 2'b00) &&
                      (64'(len) <= 64'(C_MAX_LEN));
    endfunction

    function automatic logic [15:0] f_half(input logic [63:0] w, input logic [1:0] k);
        case (k)
            2'd0:    f_half = w[15:0];
            2'd1:    f_half = w[31:16];
            2'd2:    f_half = w[47:32];
            2'd3:    f_half = w[63:48];
            default: f_half = 16'h0000;
        endcase
    endfunction

    // Last DPRAM address is taken at length width so a full-capacity readout ends on all-ones.
    assign last_idx_s     = (len_r >> 2) - P_LEN_WIDTH'(1);
    assign is_last_word_s = (P_LEN_WIDTH'(addr_r) == last_idx_s);
    assign hs_s           = out_valid_r && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        reject_s    = 1'b0;
        capture_s   = 1'b0;
        word_end_s  = 1'b0;
        final_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dpram_run) begin
                    if (f_len_legal(bus.dpram_len)) begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_RD_WAIT;
                    end else begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (wait_r == 2'(P_RD_LATENCY)) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_SHIFT: begin
                if (hs_s && (k_r == 2'd3)) begin
                    if (is_last_word_s) begin
                        final_s     = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        word_end_s  = 1'b1;
                        state_nxt_s = ST_RD_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: length latch, read address, hold register, stream word and status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_r       <= '0;
            addr_r      <= '0;
            wait_r      <= 2'd0;
            hold_r      <= 64'h0;
            k_r         <= 2'd0;
            out_data_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            n_r         <= 32'd0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (start_s || reject_s) begin
                len_r <= bus.dpram_len;
            end
            if (start_s) begin
                addr_r <= '0;
                wait_r <= 2'd0;
                busy_r <= 1'b1;
            end
            if (reject_s) begin
                err_r  <= 1'b1;
                done_r <= 1'b1;
            end
            if ((state_r == ST_RD_WAIT) && !capture_s) begin
                wait_r <= wait_r + 2'd1;
            end
            if (capture_s) begin
                hold_r      <= bus.rd_data;
                k_r         <= 2'd0;
                out_data_r  <= bus.rd_data[15:0];
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
            end else if (hs_s) begin
                if (final_s) begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    n_r         <= n_r + 32'd1;
                end else if (word_end_s) begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    addr_r      <= addr_r + P_RD_ADR_WIDTH'(1);
                    wait_r      <= 2'd0;
                end else begin
                    k_r        <= k_r + 2'd1;
                    out_data_r <= f_half(hold_r, k_r + 2'd1);
                    out_last_r <= (k_r == 2'd2) && is_last_word_s;
                end
            end
        end
    end

    assign bus.dpram_busy = busy_r;
    assign bus.dpram_done = done_r;
    assign bus.rd_addr    = addr_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_last   = out_last_r;
    assign err_len        = err_r;
    assign n_rdouts       = n_r;

endmodule
